// File: rtl/aes_bridge_pkg.sv
// Shared types and sizing helpers for the AES serial bridge.
package aes_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StShift
  } bridge_state_e;

  function automatic int unsigned msg_w(input int unsigned nb);
    return 32 * nb;
  endfunction

  function automatic int unsigned key_w(input int unsigned nk);
    return 32 * nk;
  endfunction

  function automatic int unsigned max_int(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aes_serial_bridge_if.sv
// Handshake and data bundle between the serial world, the bridge and the AES slave.
// Parity signals are present only when SERIAL_PARITY_EN is defined.
interface aes_serial_bridge_if #(
  parameter int unsigned NB    = 4,
  parameter int unsigned NK    = 8,
  parameter int unsigned LANES = 1
);
  import aes_bridge_pkg::*;

  localparam int unsigned MsgW = msg_w(NB);
  localparam int unsigned KeyW = key_w(NK);

  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_real_msg;
  logic [LANES-1:0] in_real_key;
  logic             key_reload;
  logic [MsgW-1:0]  out_slave_msg;
  logic [KeyW-1:0]  out_slave_key;
  logic             mosi;
  logic             Miso;
  logic [MsgW-1:0]  in_slave_msg;
  logic [LANES-1:0] out_real_msg;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             key_loaded;
`ifdef SERIAL_PARITY_EN
  logic             in_par;
  logic             par_err;
  logic             out_par;
`endif

  // Bridge side
  modport slave (
    input  en, in_valid, in_real_msg, in_real_key, key_reload, Miso, in_slave_msg, out_ready,
`ifdef SERIAL_PARITY_EN
    input  in_par,
    output par_err, out_par,
`endif
    output in_ready, out_slave_msg, out_slave_key, mosi, out_real_msg, out_valid, out_last,
    output key_loaded
  );

  // Environment side
  modport master (
    output en, in_valid, in_real_msg, in_real_key, key_reload, Miso, in_slave_msg, out_ready,
`ifdef SERIAL_PARITY_EN
    output in_par,
    input  par_err, out_par,
`endif
    input  in_ready, out_slave_msg, out_slave_key, mosi, out_real_msg, out_valid, out_last,
    input  key_loaded
  );

endinterface

// File: rtl/lane_shifter.sv
// LANES-wide shift register with parallel load; the same shift direction serves
// deserialising (lanes in) and reserialising (slice out) for a given bit order.
module lane_shifter #(
  parameter int unsigned W         = 128,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [W-1:0]     i_data,
  input  logic [LANES-1:0] i_lanes,
  output logic [W-1:0]     o_next,
  output logic [LANES-1:0] o_slice
);

  logic [W-1:0] r_data;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = r_data;
    if (i_load) begin
      w_next = i_data;
    end else if (i_shift) begin
      if (MSB_FIRST) w_next = {r_data[W-LANES-1:0], i_lanes};
      else           w_next = {i_lanes, r_data[W-1:LANES]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_data <= '0;
    else if (i_en) r_data <= w_next;
  end

  // Value the register takes at the coming edge, so a parent can capture the final beat.
  assign o_next  = i_en ? w_next : r_data;
  assign o_slice = MSB_FIRST ? r_data[W-1 -: LANES] : r_data[LANES-1:0];

endmodule

// File: rtl/aes_serial_bridge.sv
// Serial <-> parallel front-end for the AES slaves: loads message/key, strobes mosi,
// reserialises the result. Optional input/output parity with SERIAL_PARITY_EN.
module aes_serial_bridge #(
  parameter int unsigned NB        = 4,
  parameter int unsigned NK        = 8,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               in_clk,
  input  logic               rst,
  aes_serial_bridge_if.slave bus
);
  import aes_bridge_pkg::*;

  localparam int unsigned MsgW = msg_w(NB);
  localparam int unsigned KeyW = key_w(NK);
  localparam int unsigned Mb   = MsgW / LANES;
  localparam int unsigned Kb   = KeyW / LANES;
  localparam int unsigned MaxB = max_int(Mb, Kb);
  localparam int unsigned Cw   = $clog2(MaxB + 1);

  localparam logic [Cw-1:0] MbC     = Cw'(Mb);
  localparam logic [Cw-1:0] KbC     = Cw'(Kb);
  localparam logic [Cw-1:0] MbLast  = Cw'(Mb - 1);
  localparam logic [Cw-1:0] MaxLast = Cw'(MaxB - 1);

  bridge_state_e r_state, w_state_d;
  logic [Cw-1:0] r_cnt, w_cnt_d, w_idx, w_fl_last;
  logic          r_reload, r_key_loaded;
  logic [MsgW-1:0] r_slave_msg;
  logic [KeyW-1:0] r_slave_key;

  logic w_first, w_reload, w_in_ready, w_accept, w_msg_wr, w_key_wr, w_last_in;
  logic w_res_load, w_out_hs, w_out_last;
  logic [MsgW-1:0]  w_msg_next, w_res_next;
  logic [KeyW-1:0]  w_key_next;
  logic [LANES-1:0] w_msg_slice, w_key_slice, w_res_slice;
  logic             w_unused_ok;

  assign w_first    = (r_state == StIdle);
  assign w_in_ready = (r_state == StIdle) || (r_state == StLoad);
  assign w_accept   = bus.en && bus.in_valid && w_in_ready;
  // key_reload is only meaningful on the first beat; later beats use the latched copy.
  assign w_reload   = w_first ? bus.key_reload : r_reload;
  assign w_idx      = w_first ? '0 : r_cnt;
  assign w_fl_last  = w_reload ? MaxLast : MbLast;
  assign w_msg_wr   = w_accept && (w_idx < MbC);
  assign w_key_wr   = w_accept && w_reload && (w_idx < KbC);
  assign w_last_in  = w_accept && (w_idx == w_fl_last);
  assign w_res_load = bus.en && (r_state == StWait) && bus.Miso;
  assign w_out_last = (r_state == StShift) && (r_cnt == MbLast);
  assign w_out_hs   = bus.en && (r_state == StShift) && bus.out_ready;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle, StLoad: begin
        if (w_accept) begin
          w_cnt_d   = w_idx + Cw'(1);
          w_state_d = w_last_in ? StStart : StLoad;
        end
      end
      StStart: w_state_d = StWait;
      StWait: begin
        if (w_res_load) begin
          w_state_d = StShift;
          w_cnt_d   = '0;
        end
      end
      StShift: begin
        if (w_out_hs) begin
          if (w_out_last) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + Cw'(1);
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Slave buses capture on the last input beat so they are already valid while mosi is high.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_reload     <= 1'b0;
      r_key_loaded <= 1'b0;
      r_slave_msg  <= '0;
      r_slave_key  <= '0;
    end else if (bus.en) begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept && w_first) r_reload <= bus.key_reload;
      if (w_last_in) begin
        r_slave_msg <= w_msg_next;
        if (w_reload) begin
          r_slave_key  <= w_key_next;
          r_key_loaded <= 1'b1;
        end
      end
    end
  end

  lane_shifter #(.W(MsgW), .LANES(LANES), .MSB_FIRST(MSB_FIRST)) u_msg_in (
    .i_clk   (in_clk),
    .i_rst_n (rst),
    .i_en    (bus.en),
    .i_load  (1'b0),
    .i_shift (w_msg_wr),
    .i_data  ({MsgW{1'b0}}),
    .i_lanes (bus.in_real_msg),
    .o_next  (w_msg_next),
    .o_slice (w_msg_slice)
  );

  lane_shifter #(.W(KeyW), .LANES(LANES), .MSB_FIRST(MSB_FIRST)) u_key_in (
    .i_clk   (in_clk),
    .i_rst_n (rst),
    .i_en    (bus.en),
    .i_load  (1'b0),
    .i_shift (w_key_wr),
    .i_data  ({KeyW{1'b0}}),
    .i_lanes (bus.in_real_key),
    .o_next  (w_key_next),
    .o_slice (w_key_slice)
  );

  lane_shifter #(.W(MsgW), .LANES(LANES), .MSB_FIRST(MSB_FIRST)) u_res_out (
    .i_clk   (in_clk),
    .i_rst_n (rst),
    .i_en    (bus.en),
    .i_load  (w_res_load),
    .i_shift (w_out_hs),
    .i_data  (bus.in_slave_msg),
    .i_lanes ({LANES{1'b0}}),
    .o_next  (w_res_next),
    .o_slice (w_res_slice)
  );

  assign w_unused_ok = ^{w_msg_slice, w_key_slice, w_res_next};

  assign bus.in_ready      = w_in_ready;
  assign bus.mosi          = (r_state == StStart);
  assign bus.out_valid     = (r_state == StShift);
  assign bus.out_last      = w_out_last;
  assign bus.out_real_msg  = w_res_slice;
  assign bus.out_slave_msg = r_slave_msg;
  assign bus.out_slave_key = r_slave_key;
  assign bus.key_loaded    = r_key_loaded;

`ifdef SERIAL_PARITY_EN
  logic r_par_err;
  logic w_par_mismatch;

  assign w_par_mismatch = bus.in_par != ^(bus.in_real_msg ^ bus.in_real_key);

  // Sticky within a frame; the first beat of a frame restarts it.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst)          r_par_err <= 1'b0;
    else if (w_accept) r_par_err <= w_par_mismatch | (r_par_err & ~w_first);
  end

  assign bus.par_err = r_par_err;
  assign bus.out_par = ^w_res_slice;
`endif

endmodule

// File: tb/tb_aes_serial_bridge.sv
// Self-checking bench for aes_serial_bridge: an 8-lane/128-bit-key instance (MSB first)
// and a 1-lane/256-bit-key instance (LSB first), checked against a beat-level model.
module tb_aes_serial_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_serial_bridge_if #(.NB(4), .NK(4), .LANES(8)) a ();
  aes_serial_bridge_if #(.NB(4), .NK(8), .LANES(1)) b ();

  aes_serial_bridge #(.NB(4), .NK(4), .LANES(8), .MSB_FIRST(1'b1)) dut_a (
    .in_clk (clk),
    .rst    (rst),
    .bus    (a.slave)
  );

  aes_serial_bridge #(.NB(4), .NK(8), .LANES(1), .MSB_FIRST(1'b0)) dut_b (
    .in_clk (clk),
    .rst    (rst),
    .bus    (b.slave)
  );

  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [127:0] msg;
    logic [127:0] key;
    logic         reload;
    logic [127:0] res;
    logic [127:0] exp_key;
  } vec_t;

  vec_t tbl [6];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // MSB-first byte i of a 128-bit word.
  function automatic logic [7:0] a_beat(input logic [127:0] v, input int i);
    return v[127 - 8*i -: 8];
  endfunction

  task automatic a_frame(input logic [127:0] m, input logic [127:0] k, input logic rl,
                         input logic [127:0] exp_key);
    int beats = 0;
    int guard = 0;
    while (guard < 40) begin
      @(negedge clk);
      guard++;
      if (!a.in_ready && beats > 0) break;
      chk("a_mosi_during_load", a.mosi, 1'b0);
      chk("a_valid_during_load", a.out_valid, 1'b0);
      a.in_valid    = 1'b1;
      a.key_reload  = rl;
      a.in_real_msg = (beats < 16) ? a_beat(m, beats) : 8'($urandom);
      a.in_real_key = (rl && beats < 16) ? a_beat(k, beats) : 8'($urandom);
`ifdef SERIAL_PARITY_EN
      a.in_par = ^(a.in_real_msg ^ a.in_real_key);
`endif
      a.Miso         = (beats == 3);
      a.in_slave_msg = rnd128();
      beats++;
    end
    a.in_valid = 1'b0;
    a.Miso     = 1'b0;
    chk("a_frame_len", beats, 16);
    chk("a_mosi_rise", a.mosi, 1'b1);
    chk("a_slave_msg_at_mosi", a.out_slave_msg, m);
    @(negedge clk);
    chk("a_mosi_once", a.mosi, 1'b0);
    chk("a_slave_msg", a.out_slave_msg, m);
    chk("a_slave_key", a.out_slave_key, exp_key);
    chk("a_key_loaded", a.key_loaded, 1'b1);
    chk("a_miso_ignored", a.out_valid, 1'b0);
  endtask

  task automatic a_drain(input logic [127:0] res, input bit freeze);
    int  idx   = 0;
    int  guard = 0;
    int  held  = 0;
    bit  xfer;
    @(negedge clk);
    a.Miso = 1'b1;  a.in_slave_msg = res;  a.out_ready = 1'b0;
    @(negedge clk);
    a.Miso = 1'b0;  a.in_slave_msg = rnd128();
    chk("a_valid_latency", a.out_valid, 1'b1);
    while (idx < 16 && guard < 200) begin
      guard++;
      chk("a_out_valid", a.out_valid, 1'b1);
      chk("a_out_data", a.out_real_msg, a_beat(res, idx));
      chk("a_out_last", a.out_last, idx == 15);
      if (freeze && idx == 8 && held < 5) begin
        a.en = 1'b0;  a.out_ready = 1'b1;  held++;
      end else begin
        a.en = 1'b1;
        a.out_ready = freeze ? guard[0] : 1'($urandom_range(0, 1));
      end
      xfer = a.en && a.out_ready;
      @(negedge clk);
      if (xfer) idx++;
    end
    a.en = 1'b1;  a.out_ready = 1'b0;
    chk("a_drain_len", idx, 16);
    chk("a_back_idle_valid", a.out_valid, 1'b0);
    chk("a_back_idle_ready", a.in_ready, 1'b1);
  endtask

  task automatic b_frame(input logic [127:0] m, input logic [255:0] k, input logic rl,
                         input logic [255:0] exp_key, input int exp_len, input bit freeze);
    int beats = 0;
    int guard = 0;
    while (guard < 600) begin
      @(negedge clk);
      guard++;
      if (!b.in_ready && beats > 0) break;
      if (beats == 128) chk("b_ready_at_128", b.mosi, 1'b0);
      b.in_valid    = 1'b1;
      b.key_reload  = rl;
      b.in_real_msg = (beats < 128) ? m[beats] : 1'($urandom);
      b.in_real_key = (rl && beats < 256) ? k[beats] : 1'($urandom);
`ifdef SERIAL_PARITY_EN
      b.in_par = b.in_real_msg ^ b.in_real_key;
`endif
      beats++;
    end
    b.in_valid = 1'b0;
    chk("b_frame_len", beats, exp_len);
    chk("b_mosi_rise", b.mosi, 1'b1);
    if (freeze) begin
      b.en = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("b_mosi_frozen", b.mosi, 1'b1);
      end
      b.en = 1'b1;
    end
    @(negedge clk);
    chk("b_mosi_once", b.mosi, 1'b0);
    chk("b_slave_msg", b.out_slave_msg, m);
    chk("b_slave_key", b.out_slave_key, exp_key);
    chk("b_key_loaded", b.key_loaded, 1'b1);
  endtask

  task automatic b_drain(input logic [127:0] res);
    int idx   = 0;
    int guard = 0;
    bit xfer;
    @(negedge clk);
    b.Miso = 1'b1;  b.in_slave_msg = res;  b.out_ready = 1'b0;
    @(negedge clk);
    b.Miso = 1'b0;
    chk("b_valid_latency", b.out_valid, 1'b1);
    while (idx < 128 && guard < 1000) begin
      guard++;
      chk("b_out_data", b.out_real_msg, res[idx]);
      chk("b_out_last", b.out_last, idx == 127);
      b.en        = ($urandom_range(0, 3) != 0);
      b.out_ready = 1'($urandom_range(0, 1));
      xfer = b.en && b.out_ready;
      @(negedge clk);
      if (xfer) idx++;
    end
    b.en = 1'b1;  b.out_ready = 1'b0;
    chk("b_drain_len", idx, 128);
    chk("b_back_idle_valid", b.out_valid, 1'b0);
  endtask

  initial begin
    logic [127:0] km;
    logic [127:0] bm;
    logic [255:0] bk;

    rst = 1'b0;
    a.en = 1'b1;  a.in_valid = 1'b0;  a.in_real_msg = '0;  a.in_real_key = '0;
    a.key_reload = 1'b0;  a.Miso = 1'b0;  a.in_slave_msg = '0;  a.out_ready = 1'b0;
    b.en = 1'b1;  b.in_valid = 1'b0;  b.in_real_msg = '0;  b.in_real_key = '0;
    b.key_reload = 1'b0;  b.Miso = 1'b0;  b.in_slave_msg = '0;  b.out_ready = 1'b0;
`ifdef SERIAL_PARITY_EN
    a.in_par = 1'b0;  b.in_par = 1'b0;
`endif

    // Table: FIPS-197 frame, key-retaining frame with garbage key lanes, then random frames.
    tbl[0] = '{FipsPt, FipsKey, 1'b1, FipsCt, FipsKey};
    tbl[1] = '{rnd128(), rnd128(), 1'b0, rnd128(), FipsKey};
    km = FipsKey;
    for (int i = 2; i < 6; i++) begin
      tbl[i].msg    = rnd128();
      tbl[i].key    = rnd128();
      tbl[i].reload = 1'($urandom_range(0, 1));
      tbl[i].res    = rnd128();
      if (tbl[i].reload) km = tbl[i].key;
      tbl[i].exp_key = km;
    end

    @(negedge clk);
    chk("rst_a_slave_msg", a.out_slave_msg, '0);
    chk("rst_a_slave_key", a.out_slave_key, '0);
    chk("rst_a_mosi", a.mosi, 1'b0);
    chk("rst_a_out_valid", a.out_valid, 1'b0);
    chk("rst_a_key_loaded", a.key_loaded, 1'b0);
    chk("rst_b_out_last", b.out_last, 1'b0);
    chk("rst_b_key_loaded", b.key_loaded, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_a_ready", a.in_ready, 1'b1);

    // Wide key over a single lane: 256-beat frame, then a 128-beat key-retaining frame.
    bm = rnd128();
    bk = {rnd128(), rnd128()};
    b_frame(bm, bk, 1'b1, bk, 256, 1'b0);
    b_drain(rnd128());
    bm = rnd128();
    b_frame(bm, {rnd128(), rnd128()}, 1'b0, bk, 128, 1'b1);
    b_drain(rnd128());

    for (int i = 0; i < 6; i++) begin
      a_frame(tbl[i].msg, tbl[i].key, tbl[i].reload, tbl[i].exp_key);
      a_drain(tbl[i].res, i == 0);
    end

    // Asynchronous reset while beat 7 of a frame is on the lanes.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a.in_valid = 1'b1;  a.key_reload = 1'b1;
      a.in_real_msg = 8'($urandom);  a.in_real_key = 8'($urandom);
    end
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_slave_msg", a.out_slave_msg, '0);
    chk("mid_rst_slave_key", a.out_slave_key, '0);
    chk("mid_rst_key_loaded", a.key_loaded, 1'b0);
    chk("mid_rst_mosi", a.mosi, 1'b0);
    chk("mid_rst_out_valid", a.out_valid, 1'b0);
    chk("mid_rst_out_data", a.out_real_msg, '0);
    @(negedge clk);
    a.in_valid = 1'b0;
    rst = 1'b1;
    a.Miso = 1'b1;
    @(negedge clk);
    a.Miso = 1'b0;
    chk("idle_miso_ignored", a.out_valid, 1'b0);
    a_frame(FipsPt, FipsKey, 1'b1, FipsKey);
    a_drain(FipsCt, 1'b0);

`ifdef SERIAL_PARITY_EN
    chk("a_par_err", a.par_err, 1'b0);
    chk("b_par_err", b.par_err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_serial_bridge.md
Name: aes_serial_bridge

Overview:
- Parametrised serial front-end for the AES encryption/decryption slaves.
- Deserialises message and key from LANES-wide serial inputs and presents them in parallel to the slave. Starts the slave with a one-cycle mosi strobe.
- Captures the slave result on Miso and reserialises it with valid/ready backpressure.
- Successor to the single-bit loader. Adds multi-lane input, key retention across frames, flow control and a single posedge clock domain.

Parameters:
- NB, 4, state width in 32-bit words; MSG_W = 32*NB.
- NK, 8, key width in 32-bit words (4/6/8); KEY_W = 32*NK.
- LANES, 1, bits per beat; must divide 32.
- MSB_FIRST, 1, 1 = first beat fills the top bits; 0 = first beat fills the bottom bits.

Ports:
- in_clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when low, all state and outputs hold.
- in_valid  in  1  input beat strobe.
- in_ready  out  1  bridge accepts input beats.
- in_real_msg  in  LANES  message lanes.
- in_real_key  in  LANES  key lanes.
- key_reload  in  1  sampled on the first beat of a frame; 1 = load a new key this frame.
- out_slave_msg  out  MSG_W  parallel message to the slave.
- out_slave_key  out  KEY_W  parallel key to the slave.
- mosi  out  1  one-cycle slave start strobe.
- Miso  in  1  slave done strobe.
- in_slave_msg  in  MSG_W  slave result.
- out_real_msg  out  LANES  serial result lanes.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  marks the final output beat.
- key_loaded  out  1  a key has been captured since reset.

Behaviour:
- Reset (rst=0): asynchronous. All outputs, registers and counters go to 0; state goes to IDLE. Reset mid-frame discards all partial data.
- A beat is accepted when en && in_valid && in_ready.
- Beat counts: MB = MSG_W/LANES; KB = KEY_W/LANES.
- Frame length FL = key_reload ? max(MB,KB) : MB, latched on the first beat.
- State machine:
  - IDLE: in_ready=1. The first accepted beat latches key_reload, writes beat 0 and moves to LOAD.
  - LOAD: in_ready=1.
    - Message lanes are written for beats 0..MB-1.
    - Key lanes are written for beats 0..KB-1, only if key_reload was latched. Otherwise key lanes are ignored and the key register is retained.
    - The beat counter increments on each accepted beat. The last accepted beat (count FL-1) moves to START.
  - START: in_ready=0.
    - out_slave_msg/out_slave_key update from the shift registers.
    - mosi=1 for exactly one cycle; next state is WAIT.
    - key_loaded is set if key_reload was latched.
  - WAIT: in_ready=0. Miso=1 loads in_slave_msg into the output shift register, zeroes the output counter and moves to SHIFT. Miso in any other state is ignored.
  - SHIFT:
    - out_valid=1; out_real_msg is the current LANES slice (order per MSB_FIRST).
    - On out_valid && out_ready the register shifts by LANES and the counter increments.
    - out_last=1 on beat MB-1; its handshake moves to IDLE.
    - With out_ready=0, data holds stable.
- out_slave_msg/out_slave_key hold their values until the next START.
- Latency: mosi rises 1 cycle after the last input beat; the first out_valid appears 1 cycle after Miso.
- en=0 freezes every register and the state, including during handshakes. mosi extends across the freeze but fires only once.
- Simultaneous Miso and rst=0: reset wins.
- Counters are sized $clog2(max(MB,KB)+1) and never wrap; the counter is cleared on every transition to IDLE.

Optional Feature:
- Macro SERIAL_PARITY_EN.
- Defined:
  - Adds input in_par (1) and outputs par_err (1) and out_par (1).
  - Each accepted beat compares in_par against even parity of in_real_msg ^ in_real_key. A mismatch sets par_err, which stays sticky until the first beat of the next frame.
  - out_par is even parity of out_real_msg, valid with out_valid. The frame still proceeds on error.
- Undefined: the ports and logic are absent.

Decomposition:
- Package aes_bridge_pkg: state enum (IDLE, LOAD, START, WAIT, SHIFT), MSG_W/KEY_W helper functions, and the max() function.
- Sub-module lane_shifter (params W, LANES, MSB_FIRST; load/shift/enable): instantiated once for msg-in, once for key-in and once for result-out.

Test Plan:
- LANES=8, NK=4, key_reload=1, FIPS-197 plaintext 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f, 16 beats -> out_slave_msg/out_slave_key equal the vectors; mosi high exactly 1 cycle after beat 15; key_loaded=1.
- Second frame key_reload=0, garbage on the key lanes -> out_slave_key unchanged; frame length 16 beats.
- Miso with in_slave_msg=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready toggled 1/0 -> 16 beats 69,c4,...,5a in order; out_last on beat 15 only; data stable while stalled.
- NK=8, LANES=1, key_reload=1 -> 256 beats accepted; message complete at 128, mosi after beat 255.
- rst pulsed low during LOAD at beat 7 -> all outputs 0, state IDLE; the next frame loads cleanly.
- Miso asserted in IDLE/LOAD -> ignored; en=0 for 5 cycles mid-SHIFT -> no beats lost or duplicated.
